// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, result after WIDTH steps.
// Optional subtract mode is compiled in with `define SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_ovf;
  logic               w_accept;
  logic               w_last;
  logic               w_b_bit;
  logic [1:0]         w_fa;
  logic               w_binv;
  logic               w_carry_init;

  // Returns {carry_out, sum_bit} for a single full-adder step.
  function automatic logic [1:0] fa_step(input logic fa_a, input logic fa_b, input logic fa_c);
    return {(fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c), fa_a ^ fa_b ^ fa_c};
  endfunction

`ifdef SERIAL_ADDER_SUB_EN
  logic r_sub;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= i_sub;
    end
  end

  assign w_binv       = r_sub;
  // Subtraction is A + ~B + 1, so the carry seed replaces cin.
  assign w_carry_init = i_sub ? 1'b1 : i_cin;
`else
  assign w_binv       = 1'b0;
  assign w_carry_init = i_cin;
`endif

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_cnt == LAST_STEP);
  assign w_b_bit  = r_b[0] ^ w_binv;
  assign w_fa     = fa_step(r_a[0], w_b_bit, r_carry);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= w_carry_init;
      r_ovf   <= 1'b0;
    end else if (r_state == S_RUN) begin
      // Sum bits enter at the MSB so the first (LSB) bit lands in bit 0 after WIDTH shifts.
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= {w_fa[0], r_sum[WIDTH-1:1]};
      r_carry <= w_fa[1];
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) r_ovf <= r_carry ^ w_fa[1];
    end
  end

  assign o_sum      = r_sum;
  assign o_cout     = r_carry;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Subtract vectors are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
    .i_cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .i_sub      (sub),
`endif
    .o_busy     (busy),
    .o_done     (done),
    .o_sum      (sum),
    .o_cout     (cout),
    .o_overflow (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`else
    if (s) $display("note: subtract vector skipped in add-only build");
`endif
  endtask

  // Launch one operation; operands are scrambled during RUN, and at sample
  // index 'glitch' a stray start is driven to prove it is ignored.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts, input int glitch,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    int n;
    int nbusy;
    a = ta; b = tb_v; cin = tc; set_sub(ts);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    n = 0;
    nbusy = 0;
    while (!done && n < 4 * W) begin
      if (busy) nbusy++;
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      start = (n == glitch);
      tick();
      n++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(W));
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    tick();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_sum_hold"}, 64'(sum), 64'(es));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int last;
    int cnt;
    int ndone;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; set_sub(1'b0);
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1; a = 8'h12; b = 8'h34;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("rst_over_start_busy", 64'(busy), 64'd0);
    tick();
    chk("rst_over_start_busy2", 64'(busy), 64'd0);

    run_op("v5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, -1, 8'h96, 1'b0, 1'b1);
    run_op("vff01", 8'hFF, 8'h01, 1'b0, 1'b0, -1, 8'h00, 1'b1, 1'b0);
    run_op("v8080", 8'h80, 8'h80, 1'b0, 1'b0, -1, 8'h00, 1'b1, 1'b1);
    run_op("v0000c", 8'h00, 8'h00, 1'b1, 1'b0, -1, 8'h01, 1'b0, 1'b0);
    run_op("v7f01", 8'h7F, 8'h01, 1'b0, 1'b0, -1, 8'h80, 1'b0, 1'b1);
    run_op("glitch", 8'h12, 8'h34, 1'b1, 1'b0, 2, 8'h47, 1'b0, 1'b0);

    // Abort with reset at RUN step 4.
    a = 8'hC8; b = 8'h64; cin = 1'b0; set_sub(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    ndone = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_op("after_abort", 8'hC8, 8'h64, 1'b0, 1'b0, -1, 8'h2C, 1'b1, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub0507", 8'h05, 8'h07, 1'b0, 1'b1, -1, 8'hFE, 1'b0, 1'b0);
    run_op("sub8001", 8'h80, 8'h01, 1'b1, 1'b1, -1, 8'h7F, 1'b1, 1'b1);
    set_sub(1'b0);
`endif

    // Start held high: back-to-back operations with fixed operands.
    a = 8'h11; b = 8'h22; cin = 1'b0;
    start = 1'b1;
    cyc = 0; last = -1; cnt = 0;
    while (cnt < 3 && cyc < 60) begin
      tick();
      cyc++;
      if (done) begin
        chk("b2b_sum", 64'(sum), 64'h33);
        if (last >= 0) chk("b2b_gap", 64'(cyc - last), 64'(W + 2));
        last = cyc;
        cnt++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 64'(cnt), 64'd3);
    tick();
    chk("b2b_idle_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
